vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing master for the 640x480@60 Hz VGA output. It produces the `DrawX`/`DrawY` scan coordinates and the `blank` visible-area flag that the sprite, spike and background renderers consume. It also generates `hs`/`vs` sync. Delayed copies of `hs`, `vs` and `blank` line up with the renderers' ROM-plus-output-register latency, so the RGB values and sync reach the DAC pins on the same clock edge.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch, in clocks
- `H_SYNC`, 96: horizontal sync width, in clocks
- `H_BACK`, 48: horizontal back porch, in clocks
- `V_VISIBLE`, 480: visible lines per frame
- `V_FRONT`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vertical sync width, in lines
- `V_BACK`, 33: vertical back porch, in lines
- `PIPE_DELAY`, 2: renderer latency in clocks; legal range 0..4
- `vga_clk`  in  1  pixel clock, 25 MHz; the block's only clock
- `reset`  in  1  asynchronous, active-high reset
- `DrawX`  out  10  current horizontal count, 0..H_TOTAL-1
- `DrawY`  out  10  current vertical count, 0..V_TOTAL-1
- `blank`  out  1  1 = (DrawX,DrawY) is in the visible area
- `hs`  out  1  horizontal sync, active-low, aligned with DrawX
- `vs`  out  1  vertical sync, active-low, aligned with DrawY
- `line_start`  out  1  one-clock pulse when DrawX==0
- `frame_start`  out  1  one-clock pulse when DrawX==0 and DrawY==0
- `hs_d`, `vs_d`, `blank_d`  out  1 each  copies of `hs`, `vs` and `blank` delayed by PIPE_DELAY clocks; these drive the pins
- `sync`  out  1  composite sync, tied to 0

## Operation
- Totals:
  - H_TOTAL = sum of the four H parameters = 800.
  - V_TOTAL = sum of the four V parameters = 525.
- Horizontal counter `h`:
  - Increments every clock.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter `v`:
  - Increments only on the clock where `h` wraps.
  - If `v` is at V_TOTAL-1 when that wrap occurs, it wraps to 0.
- `DrawX` = `h`, `DrawY` = `v`. Both are registers, not combinational decodes.
- `hs`, `vs`, `blank`, `line_start` and `frame_start` are registered. Each is decoded from the next-state counter values, so it changes on the same edge as `DrawX`/`DrawY`, with zero relative skew:
  - `blank` = (h < H_VISIBLE) && (v < V_VISIBLE).
  - `hs` = 0 iff h ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656, 751].
  - `vs` = 0 iff v ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] = [490, 491]. `vs` spans whole lines and changes only at h wrap.
- Delay line:
  - `hs_d`, `vs_d` and `blank_d` come from a PIPE_DELAY-deep shift register.
  - With PIPE_DELAY = 0 they equal `hs`, `vs` and `blank` directly.
- Reset:
  - While `reset` is high, the counters sit at the last pixel of the frame, (799, 524).
  - Outputs during reset: DrawX=799, DrawY=524, blank=0, hs=1, vs=1, line_start=0, frame_start=0. All delay-line stages hold the same inactive values: hs_d=1, vs_d=1, blank_d=0.
  - Asserting `reset` mid-frame forces these values immediately, without waiting for a clock.
- There is no handshake. The block free-runs and never stalls.

## Timing
- First rising edge after `reset` deasserts: DrawX=0, DrawY=0, blank=1, line_start=1, frame_start=1.
- Line period is 800 clocks; frame period is 420000 clocks.
- `line_start` is high exactly 1 clock in every 800.
- `frame_start` is high exactly 1 clock in every 420000.
- `hs` low width is 96 clocks; `vs` low width is 1600 clocks (2 lines).
- `blank_d` rises exactly PIPE_DELAY clocks after `blank` rises; `hs_d` and `vs_d` lag `hs` and `vs` by the same amount.
- Counter arithmetic is 10-bit unsigned, and no value ever exceeds 799. Comparisons use the parameter constants; there are no multipliers.

## Structure
- Package `vga_timing_pkg` holds:
  - the eight timing constants;
  - the derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START and VS_END;
  - typedef `coord_t` = `logic [9:0]`.
- Sub-module `vga_pipe_delay`:
  - a parameterised-depth, 3-bit-wide shift register with asynchronous reset to {hs=1, vs=1, blank=0};
  - handles DEPTH=0 as a pass-through.

## Test plan
- Reset release → next edge gives DrawX=0, DrawY=0, blank=1, frame_start=1, hs=1, vs=1. Before that edge the outputs read 799, 524, blank=0.
- Run one line → DrawX reaches 639 with blank=1. blank=0 from DrawX=640. hs=0 exactly for DrawX 656..751. Wrap 799→0 gives DrawY=1 and line_start=1.
- Run a full frame → vs=0 only for DrawY 490..491. blank=0 for all of DrawY ≥ 480. Next frame_start arrives 420000 clocks after the first.
- PIPE_DELAY=2 → blank_d rises 2 clocks after blank, and hs_d falls 2 clocks after hs, at DrawX=658.
- Assert `reset` asynchronously at DrawX=300, DrawY=200 → outputs go to reset values immediately. Release → restart at (0,0) with frame_start=1.
- PIPE_DELAY=0 → hs_d, vs_d and blank_d are identical to hs, vs and blank on every cycle of a frame.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the 640x480@60 Hz VGA timing master.
// Holds the eight raw porch/sync/visible constants, the derived totals and
// sync windows, the coordinate type, the sync/blank bundle carried through
// the renderer-latency delay line, and a small range helper.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    // Derived totals and sync windows (inclusive bounds)
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = H_VISIBLE + H_FRONT + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = V_VISIBLE + V_FRONT + V_SYNC - 1;

    // Scan coordinate; 10 bits covers 0..799 and 0..524
    typedef logic [9:0] coord_t;

    // Signals that travel through the renderer-latency delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_bits_t;

    // Inactive level of the bundle: syncs deasserted (high), not visible
    localparam sync_bits_t SYNC_BITS_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    // Inclusive window test on a coordinate
    function automatic logic in_window(input coord_t val, input coord_t lo, input coord_t hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pipe_delay.sv
// ---------------------------------------------------------------------------
// vga_pipe_delay
// Fixed-depth shift register for the {hs, vs, blank} bundle, so the sync and
// blank signals reach the pins on the same edge as the renderers' RGB.
//   clk_i   in   pixel clock
//   rst_i   in   asynchronous active-high reset; all stages load the idle word
//   data_i  in   {hs, vs, blank} aligned with DrawX/DrawY
//   data_o  out  data_i delayed by DEPTH clocks (DEPTH=0 is a pass-through)
// ---------------------------------------------------------------------------
module vga_pipe_delay
    import vga_timing_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  sync_bits_t data_i,
    output sync_bits_t data_o
);

    if (DEPTH == 0) begin : g_passthru
        assign data_o = data_i;
    end else begin : g_shift
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            sync_bits_t stage_q;
            sync_bits_t stage_d;

            // Stage 0 takes the live bundle, later stages take their predecessor
            if (gi == 0) begin : g_head
                assign stage_d = data_i;
            end else begin : g_tail
                assign stage_d = g_stage[gi-1].stage_q;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stage_q <= SYNC_BITS_IDLE;
                end else begin
                    stage_q <= stage_d;
                end
            end
        end

        assign data_o = g_stage[DEPTH-1].stage_q;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Pixel-timing master for 640x480@60 Hz VGA. Free-running horizontal and
// vertical counters provide the scan coordinate; sync, blank and the
// line/frame strobes are decoded from the next-state counter values and
// registered so they change on the same edge as DrawX/DrawY.
//   vga_clk      in   pixel clock (25 MHz)
//   reset        in   asynchronous active-high reset
//   DrawX/DrawY  out  current scan coordinate (registered)
//   blank        out  1 while (DrawX,DrawY) is in the visible area
//   hs/vs        out  active-low syncs aligned with DrawX/DrawY
//   line_start   out  one-clock pulse at DrawX==0
//   frame_start  out  one-clock pulse at DrawX==0, DrawY==0
//   hs_d/vs_d/blank_d  out  hs/vs/blank delayed by PIPE_DELAY (0..4) clocks
//   sync         out  composite sync, unused, tied low
// During reset the counters park on the last pixel of the frame so the
// first edge after release lands on (0,0) with frame_start high.
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
    parameter int unsigned PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d,
    output logic       sync
);

    // Timing constants narrowed to the coordinate width
    localparam coord_t H_LAST  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam coord_t V_LAST  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
    localparam coord_t HS_LO   = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_HI   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_LO   = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_HI   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    coord_t h_q, h_d;
    coord_t v_q, v_d;
    logic   h_wrap;

    logic blank_q, blank_next;
    logic hs_q, hs_next;
    logic vs_q, vs_next;
    logic line_start_q, line_start_next;
    logic frame_start_q, frame_start_next;

    sync_bits_t pipe_in;
    sync_bits_t pipe_out;

    // ------------------------------------------------------------------
    // Next-state counters
    // ------------------------------------------------------------------
    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? '0 : h_q + coord_t'(1);
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Decode from the next-state coordinate so the registered flags are
    // valid for the same coordinate that DrawX/DrawY present.
    // vs depends only on v_d, which moves only at the h wrap, so it spans
    // whole lines.
    // ------------------------------------------------------------------
    always_comb begin
        blank_next       = (h_d < H_VIS_C) && (v_d < V_VIS_C);
        hs_next          = ~in_window(h_d, HS_LO, HS_HI);
        vs_next          = ~in_window(v_d, VS_LO, VS_HI);
        line_start_next  = (h_d == '0);
        frame_start_next = (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            blank_q       <= blank_next;
            hs_q          <= hs_next;
            vs_q          <= vs_next;
            line_start_q  <= line_start_next;
            frame_start_q <= frame_start_next;
        end
    end

    // ------------------------------------------------------------------
    // Renderer-latency delay line for the pin-side sync and blank
    // ------------------------------------------------------------------
    assign pipe_in = '{hs: hs_q, vs: vs_q, blank: blank_q};

    vga_pipe_delay #(
        .DEPTH (PIPE_DELAY)
    ) u_pipe (
        .clk_i  (vga_clk),
        .rst_i  (reset),
        .data_i (pipe_in),
        .data_o (pipe_out)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign DrawX       = h_q;
    assign DrawY       = v_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hs_d        = pipe_out.hs;
    assign vs_d        = pipe_out.vs;
    assign blank_d     = pipe_out.blank;
    assign sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three instances share clock and reset: full 640x480 timing with a 2-clock
// delay line, the same with no delay line, and a miniature timing set with a
// 3-clock delay line so whole frames fit in a short run. A reference model
// derives every output from the number of clock edges since reset release.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hsy, hb;
        int vv, vf, vsy, vb;
        int d;
    } cfg_t;

    localparam cfg_t CFG_D2 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    localparam cfg_t CFG_D0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    localparam cfg_t CFG_SM = '{8, 2, 3, 2, 4, 2, 2, 1, 3};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;      // edges since reset release; 0 = in / just out of reset
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // DUT outputs
    logic [9:0] x2, y2, x0, y0, xs, ys;
    logic b2, h2, v2, l2, f2, hd2, vd2, bd2, s2;
    logic b0, h0, v0, l0, f0, hd0, vd0, bd0, s0;
    logic bs, hs_s, vs_s, ls, fs, hds, vds, bds, ss;

    vga_timing_gen #(.PIPE_DELAY(2)) u_d2 (
        .vga_clk(clk), .reset(rst), .DrawX(x2), .DrawY(y2), .blank(b2), .hs(h2), .vs(v2),
        .line_start(l2), .frame_start(f2), .hs_d(hd2), .vs_d(vd2), .blank_d(bd2), .sync(s2));

    vga_timing_gen #(.PIPE_DELAY(0)) u_d0 (
        .vga_clk(clk), .reset(rst), .DrawX(x0), .DrawY(y0), .blank(b0), .hs(h0), .vs(v0),
        .line_start(l0), .frame_start(f0), .hs_d(hd0), .vs_d(vd0), .blank_d(bd0), .sync(s0));

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(1), .PIPE_DELAY(3)
    ) u_sm (
        .vga_clk(clk), .reset(rst), .DrawX(xs), .DrawY(ys), .blank(bs), .hs(hs_s), .vs(vs_s),
        .line_start(ls), .frame_start(fs), .hs_d(hds), .vs_d(vds), .blank_d(bds), .sync(ss));

    // ------------------------------------------------------------------
    // Reference model: the live signals at edge count c. c<=0 is the
    // reset state; otherwise pixel index t=c-1 from the start of frame 0.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic blank, hs, vs, ls, fs;
    } live_t;

    function automatic live_t model_live(input cfg_t c_cfg, input int c);
        live_t r;
        int ht, vt, t, h, v;
        ht = c_cfg.hv + c_cfg.hf + c_cfg.hsy + c_cfg.hb;
        vt = c_cfg.vv + c_cfg.vf + c_cfg.vsy + c_cfg.vb;
        if (c <= 0) begin
            r.x = 10'(ht - 1); r.y = 10'(vt - 1);
            r.blank = 1'b0; r.hs = 1'b1; r.vs = 1'b1; r.ls = 1'b0; r.fs = 1'b0;
        end else begin
            t = c - 1;
            h = t % ht;
            v = (t / ht) % vt;
            r.x = 10'(h); r.y = 10'(v);
            r.blank = (h < c_cfg.hv) && (v < c_cfg.vv);
            r.hs = !((h >= c_cfg.hv + c_cfg.hf) && (h < c_cfg.hv + c_cfg.hf + c_cfg.hsy));
            r.vs = !((v >= c_cfg.vv + c_cfg.vf) && (v < c_cfg.vv + c_cfg.vf + c_cfg.vsy));
            r.ls = (h == 0);
            r.fs = (h == 0) && (v == 0);
        end
        return r;
    endfunction

    // Full output vector: {x, y, blank, hs, vs, ls, fs, hs_d, vs_d, blank_d, sync}
    function automatic logic [28:0] model_out(input cfg_t c_cfg, input int c);
        live_t now, old;
        now = model_live(c_cfg, c);
        old = model_live(c_cfg, c - c_cfg.d);
        return {now.x, now.y, now.blank, now.hs, now.vs, now.ls, now.fs,
                old.hs, old.vs, old.blank, 1'b0};
    endfunction

    task automatic cmp_vec(input string nm, input cfg_t c_cfg, input logic [28:0] act);
        logic [28:0] exp;
        exp = model_out(c_cfg, cyc);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual={x=%0d y=%0d flags=%b} required={x=%0d y=%0d flags=%b}",
                     nm, cyc, act[28:19], act[18:9], act[8:0], exp[28:19], exp[18:9], exp[8:0]);
        end
    endtask

    // Per-cycle compare of every instance against the model
    always @(negedge clk) begin
        cmp_vec("d2", CFG_D2, {x2, y2, b2, h2, v2, l2, f2, hd2, vd2, bd2, s2});
        cmp_vec("d0", CFG_D0, {x0, y0, b0, h0, v0, l0, f0, hd0, vd0, bd0, s0});
        cmp_vec("sm", CFG_SM, {xs, ys, bs, hs_s, vs_s, ls, fs, hds, vds, bds, ss});
    end

    // Strobe periodicity: small-frame period 15*9=135, line period 800
    int last_fs = 0;
    int last_ls = 0;
    always @(negedge clk) begin
        if (rst) begin
            last_fs = 0;
            last_ls = 0;
        end else begin
            if (fs) begin
                if (last_fs != 0) begin
                    checks++;
                    if (cyc - last_fs != 135) begin
                        errors++;
                        $display("FAIL sm_frame_period actual=%0d required=135", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
            if (l2) begin
                if (last_ls != 0) begin
                    checks++;
                    if (cyc - last_ls != 800) begin
                        errors++;
                        $display("FAIL d2_line_period actual=%0d required=800", cyc - last_ls);
                    end
                end
                last_ls = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic goto(input int target);
        for (int k = 0; k < 20000 && cyc != target; k++) @(negedge clk);
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL goto actual=%0d required=%0d", cyc, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("pre_edge_x", int'(x2), 799);
        chk("pre_edge_y", int'(y2), 524);
        chk("pre_edge_blank", int'(b2), 0);

        goto(1);
        chk("first_x", int'(x2), 0);
        chk("first_y", int'(y2), 0);
        chk("first_blank", int'(b2), 1);
        chk("first_frame_start", int'(f2), 1);
        chk("first_line_start", int'(l2), 1);
        chk("first_hs", int'(h2), 1);
        chk("first_vs", int'(v2), 1);
        chk("d2_blank_d_c1", int'(bd2), 0);
        chk("d0_blank_d_c1", int'(bd0), 1);
        goto(2);
        chk("d2_blank_d_c2", int'(bd2), 0);
        goto(3);
        chk("d2_blank_d_c3", int'(bd2), 1);
        goto(90);
        chk("sm_vs_before", int'(vs_s), 1);
        goto(91);
        chk("sm_vs_start_y", int'(ys), 6);
        chk("sm_vs_start", int'(vs_s), 0);
        goto(120);
        chk("sm_vs_end", int'(vs_s), 0);
        goto(121);
        chk("sm_vs_after", int'(vs_s), 1);
        goto(136);
        chk("sm_second_frame_x", int'(xs), 0);
        chk("sm_second_frame_y", int'(ys), 0);
        chk("sm_second_frame_fs", int'(fs), 1);
        goto(640);
        chk("x639", int'(x2), 639);
        chk("blank_at_639", int'(b2), 1);
        goto(641);
        chk("blank_at_640", int'(b2), 0);
        goto(657);
        chk("hs_at_656", int'(h2), 0);
        chk("hs_d_at_656", int'(hd2), 1);
        goto(659);
        chk("x658", int'(x2), 658);
        chk("hs_d_at_658", int'(hd2), 0);
        goto(752);
        chk("hs_at_751", int'(h2), 0);
        goto(753);
        chk("hs_at_752", int'(h2), 1);
        goto(801);
        chk("wrap_x", int'(x2), 0);
        chk("wrap_y", int'(y2), 1);
        chk("wrap_line_start", int'(l2), 1);
        chk("wrap_frame_start", int'(f2), 0);

        // Asynchronous reset mid-frame at (300,3)
        goto(2701);
        chk("mid_x", int'(x2), 300);
        chk("mid_y", int'(y2), 3);
        #2 rst = 1'b1;
        #1;
        chk("async_x", int'(x2), 799);
        chk("async_y", int'(y2), 524);
        chk("async_blank", int'(b2), 0);
        chk("async_hs_d", int'(hd2), 1);
        chk("async_blank_d", int'(bd2), 0);
        chk("async_sm_x", int'(xs), 14);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        goto(1);
        chk("restart_x", int'(x2), 0);
        chk("restart_y", int'(y2), 0);
        chk("restart_frame_start", int'(f2), 1);

        goto(1200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
